fp32_stb_multiplier: RTL and testbench

Sequential IEEE-754 single-precision multiplier. It implements the responder side of the team's stb/ack operand/result handshake: input_a/input_b operand strobes and acks, output_z result strobe and ack. It drops in wherever column_multiplier-style initiators need one product per request, and is a self-contained alternative to the existing multiplier core. Denormals are flushed to zero and rounding is round-to-nearest-even.

---
 rtl/fp32_stb_multiplier_if.sv | 24 ++
 rtl/fp32_stb_multiplier.sv | 176 +++++++++++++++++
 tb/tb_fp32_stb_multiplier.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fp32_stb_multiplier_if.sv
// Operand/result stb-ack bundle between an initiator (master) and the multiplier (slave).
// Purely structural: carries two fp32 operands in and one fp32 product out.
// Each direction is qualified by its own strobe and acknowledged by the opposite side.
interface fp32_stb_multiplier_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/fp32_stb_multiplier.sv
// Sequential fp32 multiplier (flush-to-zero, round-to-nearest-even) behind an stb/ack handshake.
// Latency from B capture to output_z_stb: 29 edges normal path, 3 edges for special/zero operands.
// Backpressure: output_z/output_z_stb hold indefinitely until output_z_ack; no operand acked meanwhile.
module fp32_stb_multiplier #(
  parameter int          MULT_STEPS = 24,
  parameter logic [31:0] QNAN       = 32'h7FC00000
) (
  input logic                  in_clk,
  input logic                  in_reset,
  fp32_stb_multiplier_if.slave bus
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, MULT, NORMALISE, ROUND, PACK, PUT_Z
  } state_t;

  state_t             r_state;
  logic [31:0]        r_a, r_b, r_z;
  logic               r_a_ack, r_b_ack, r_z_stb;
  logic               r_sa, r_sb, r_sign;
  logic [7:0]         r_ea, r_eb;
  logic [23:0]        r_ma, r_mb, r_mant;
  logic signed [9:0]  r_exp;
  logic [47:0]        r_prod;
  logic [4:0]         r_cnt;
  logic               r_g, r_r, r_s;

  // Operand classification; mantissas already carry the hidden bit (or are zero when flushed).
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  assign w_a_nan  = (r_ea == 8'hFF) && (r_ma[22:0] != 23'd0);
  assign w_b_nan  = (r_eb == 8'hFF) && (r_mb[22:0] != 23'd0);
  assign w_a_inf  = (r_ea == 8'hFF) && (r_ma[22:0] == 23'd0);
  assign w_b_inf  = (r_eb == 8'hFF) && (r_mb[22:0] == 23'd0);
  assign w_a_zero = (r_ea == 8'd0);
  assign w_b_zero = (r_eb == 8'd0);

  // One shift-add partial product per MULT cycle, selected by the current multiplier bit.
  logic [47:0] w_addend;
  assign w_addend = r_mb[r_cnt] ? ({24'd0, r_ma} << r_cnt) : 48'd0;

  // Round-to-nearest-even decision and the incremented mantissa with its carry-out.
  logic        w_round_up;
  logic [24:0] w_rnd_sum;
  assign w_round_up = r_g & (r_r | r_s | r_mant[0]);
  assign w_rnd_sum  = {1'b0, r_mant} + 25'd1;

  assign bus.input_a_ack  = r_a_ack;
  assign bus.input_b_ack  = r_b_ack;
  assign bus.output_z     = r_z;
  assign bus.output_z_stb = r_z_stb;

  // Control FSM and datapath; all handshake outputs are registered here.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_state <= GET_A;
      r_a     <= '0;
      r_b     <= '0;
      r_z     <= '0;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_z_stb <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_sign  <= 1'b0;
      r_ea    <= '0;
      r_eb    <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_mant  <= '0;
      r_exp   <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_g     <= 1'b0;
      r_r     <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      case (r_state)
        GET_A: begin
          // First edge after reset only raises the ack; capture needs the ack already visible.
          if (!r_a_ack) begin
            r_a_ack <= 1'b1;
          end else if (bus.input_a_stb) begin
            r_a     <= bus.input_a;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b1;
            r_state <= GET_B;
          end
        end
        GET_B: begin
          if (bus.input_b_stb) begin
            r_b     <= bus.input_b;
            r_b_ack <= 1'b0;
            r_state <= UNPACK;
          end
        end
        UNPACK: begin
          r_sa    <= r_a[31];
          r_sb    <= r_b[31];
          r_ea    <= r_a[30:23];
          r_eb    <= r_b[30:23];
          r_ma    <= (r_a[30:23] == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
          r_mb    <= (r_b[30:23] == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
          r_state <= SPECIAL;
        end
        SPECIAL: begin
          r_sign <= r_sa ^ r_sb;
          if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            r_z     <= QNAN;
            r_state <= PUT_Z;
          end else if (w_a_inf || w_b_inf) begin
            r_z     <= {r_sa ^ r_sb, 31'h7F800000};
            r_state <= PUT_Z;
          end else if (w_a_zero || w_b_zero) begin
            r_z     <= {r_sa ^ r_sb, 31'd0};
            r_state <= PUT_Z;
          end else begin
            r_exp   <= $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - 10'sd127;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_state <= MULT;
          end
        end
        MULT: begin
          r_prod <= r_prod + w_addend;
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'(MULT_STEPS - 1)) r_state <= NORMALISE;
        end
        NORMALISE: begin
          if (r_prod[47]) begin
            r_mant <= r_prod[47:24];
            r_g    <= r_prod[23];
            r_r    <= r_prod[22];
            r_s    <= |r_prod[21:0];
            r_exp  <= r_exp + 10'sd1;
          end else begin
            r_mant <= r_prod[46:23];
            r_g    <= r_prod[22];
            r_r    <= r_prod[21];
            r_s    <= |r_prod[20:0];
          end
          r_state <= ROUND;
        end
        ROUND: begin
          if (w_round_up) begin
            if (w_rnd_sum[24]) begin
              r_mant <= w_rnd_sum[24:1];
              r_exp  <= r_exp + 10'sd1;
            end else begin
              r_mant <= w_rnd_sum[23:0];
            end
          end
          r_state <= PACK;
        end
        PACK: begin
          if (r_exp >= 10'sd255)    r_z <= {r_sign, 31'h7F800000};
          else if (r_exp <= 10'sd0) r_z <= {r_sign, 31'd0};
          else                      r_z <= {r_sign, r_exp[7:0], r_mant[22:0]};
          r_z_stb <= 1'b1;
          r_state <= PUT_Z;
        end
        PUT_Z: begin
          // Special results arrive with the strobe low and raise it one edge later.
          if (!r_z_stb) begin
            r_z_stb <= 1'b1;
          end else if (bus.output_z_ack) begin
            r_z_stb <= 1'b0;
            r_a_ack <= 1'b1;
            r_state <= GET_A;
          end
        end
        default: r_state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_stb_multiplier.sv
// Self-checking bench for fp32_stb_multiplier: directed vector table, reset/backpressure sequences,
// and randomized operands compared against an arithmetic reference model.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_fp32_stb_multiplier;

  logic in_clk;
  logic in_reset;
  int   checks;
  int   failures;

  fp32_stb_multiplier_if ifc ();

  fp32_stb_multiplier #(.MULT_STEPS(24), .QNAN(32'h7FC00000)) dut (
    .in_clk  (in_clk),
    .in_reset(in_reset),
    .bus     (ifc)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    bit          special;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: decode, exact integer product, round-to-nearest-even by remainder comparison.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e, sh;
    longint      fa, fb, p, m, rem, half;
    logic [31:0] res;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
        (ea == 255 && eb == 0) || (ea == 0 && eb == 255)) return 32'h7FC00000;
    if (ea == 255 || eb == 255) return {s, 31'h7F800000};
    if (ea == 0 || eb == 0) return {s, 31'd0};
    p = (fa + 64'h800000) * (fb + 64'h800000);
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    m    = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 31'h7F800000};
    if (e <= 0) return {s, 31'd0};
    res = {s, e[7:0], m[22:0]};
    return res;
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) || (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  // At most one of the three handshake outputs may be high at any moment.
  always @(negedge in_clk) begin
    if (in_reset)
      chk("onehot", {31'd0, (32'(ifc.input_a_ack) + 32'(ifc.input_b_ack) + 32'(ifc.output_z_stb)) > 1}, 32'd0);
  end

  // One complete transaction; returns product and edges from B capture to z_stb.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] z, output int lat);
    int n;
    ifc.input_a     = a;
    ifc.input_b     = b;
    ifc.input_a_stb = 1'b1;
    ifc.input_b_stb = 1'b1;
    n = 0;
    while (!ifc.input_b_ack && n < 200) begin
      @(posedge in_clk); #1;
      n++;
    end
    if (n >= 200) chk("b_ack_timeout", 32'd1, 32'd0);
    @(posedge in_clk); #1;
    chk("b_captured", {31'd0, ifc.input_b_ack}, 32'd0);
    ifc.input_a_stb = 1'b0;
    ifc.input_b_stb = 1'b0;
    lat = 0;
    while (!ifc.output_z_stb && lat < 100) begin
      @(posedge in_clk); #1;
      lat++;
    end
    z = ifc.output_z;
    for (int i = 0; i < hold; i++) begin
      @(posedge in_clk); #1;
      chk("hold_z", ifc.output_z, z);
      chk("hold_stb", {31'd0, ifc.output_z_stb}, 32'd1);
      chk("hold_acks", {30'd0, ifc.input_a_ack, ifc.input_b_ack}, 32'd0);
    end
    ifc.output_z_ack = 1'b1;
    @(posedge in_clk); #1;
    ifc.output_z_ack = 1'b0;
    chk("stb_drop", {31'd0, ifc.output_z_stb}, 32'd0);
    chk("a_ack_back", {31'd0, ifc.input_a_ack}, 32'd1);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] z, a, b;
    int          lat;

    checks           = 0;
    failures         = 0;
    in_reset         = 1'b0;
    ifc.input_a      = '0;
    ifc.input_b      = '0;
    ifc.input_a_stb  = 1'b0;
    ifc.input_b_stb  = 1'b0;
    ifc.output_z_ack = 1'b0;

    vecs.push_back('{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0});
    vecs.push_back('{32'h3FC00000, 32'hC0200000, 32'hC0700000, 1'b0});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1});
    vecs.push_back('{32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b1});
    vecs.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1});
    vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1});
    vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 1'b1});
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 1'b1});
    vecs.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0});
    vecs.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 1'b0});

    // Reset state.
    #12;
    chk("rst_a_ack", {31'd0, ifc.input_a_ack}, 32'd0);
    chk("rst_b_ack", {31'd0, ifc.input_b_ack}, 32'd0);
    chk("rst_z_stb", {31'd0, ifc.output_z_stb}, 32'd0);
    chk("rst_z", ifc.output_z, 32'd0);
    @(posedge in_clk); #1;
    in_reset = 1'b1;
    chk("a_ack_pre", {31'd0, ifc.input_a_ack}, 32'd0);
    @(posedge in_clk); #1;
    chk("a_ack_first_edge", {31'd0, ifc.input_a_ack}, 32'd1);

    // Directed table.
    foreach (vecs[i]) begin
      chk($sformatf("model_v%0d", i), ref_mul(vecs[i].a, vecs[i].b), vecs[i].z);
      run_txn(vecs[i].a, vecs[i].b, 0, z, lat);
      chk($sformatf("z_v%0d", i), z, vecs[i].z);
      chk($sformatf("lat_v%0d", i), 32'(lat), vecs[i].special ? 32'd3 : 32'd29);
    end

    // Output backpressure for 10 cycles.
    run_txn(32'h3FC00000, 32'hC0200000, 10, z, lat);
    chk("bp_z", z, 32'hC0700000);

    // Reset in MULT cycle 10 abandons the operation.
    ifc.input_a     = 32'h3FC00000;
    ifc.input_b     = 32'h40000000;
    ifc.input_a_stb = 1'b1;
    ifc.input_b_stb = 1'b1;
    lat = 0;
    while (!ifc.input_b_ack && lat < 200) begin
      @(posedge in_clk); #1;
      lat++;
    end
    @(posedge in_clk); #1;
    ifc.input_a_stb = 1'b0;
    ifc.input_b_stb = 1'b0;
    repeat (12) @(posedge in_clk);
    #1;
    in_reset = 1'b0;
    #1;
    chk("mrst_a_ack", {31'd0, ifc.input_a_ack}, 32'd0);
    chk("mrst_b_ack", {31'd0, ifc.input_b_ack}, 32'd0);
    chk("mrst_z_stb", {31'd0, ifc.output_z_stb}, 32'd0);
    chk("mrst_z", ifc.output_z, 32'd0);
    @(posedge in_clk); #1;
    in_reset = 1'b1;
    chk("mrst_a_ack_pre", {31'd0, ifc.input_a_ack}, 32'd0);
    @(posedge in_clk); #1;
    chk("mrst_a_ack_edge", {31'd0, ifc.input_a_ack}, 32'd1);
    run_txn(32'h40000000, 32'h40000000, 0, z, lat);
    chk("mrst_next_z", z, 32'h40800000);
    chk("mrst_next_lat", 32'(lat), 32'd29);

    // Randomized operands, mostly in a range that keeps results normal.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        a[30:23] = 8'($urandom_range(60, 190));
        b[30:23] = 8'($urandom_range(60, 190));
      end
      run_txn(a, b, $urandom_range(0, 2), z, lat);
      chk($sformatf("rnd_z_%h_%h", a, b), z, ref_mul(a, b));
      chk($sformatf("rnd_lat_%h_%h", a, b), 32'(lat), is_special(a, b) ? 32'd3 : 32'd29);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
